// File: rtl/compare_sched_pkg.sv
// Shared types for compare_sched: FSM state encoding, result sign codes and a
// wrap-around index helper used by the round-robin arbiter.
package compare_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic [1:0] SIGN_GT = 2'b10;
  localparam logic [1:0] SIGN_EQ = 2'b01;
  localparam logic [1:0] SIGN_LT = 2'b00;

  localparam int unsigned STATS_W = 16;

  // Next index in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/compare_core.sv
// Registered unsigned comparator: sign_result reflects A versus MCONSTANT one
// clock after A is presented.
module compare_core
  import compare_sched_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 18,
  parameter logic [DATA_WIDTH-1:0]  MCONSTANT  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] A,
  output logic [1:0]            sign_result
);

  logic [1:0] sign_next;

  always_comb begin
    if (A > MCONSTANT)       sign_next = SIGN_GT;
    else if (A == MCONSTANT) sign_next = SIGN_EQ;
    else                     sign_next = SIGN_LT;
  end

  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sign_result <= SIGN_LT;
    else       sign_result <= sign_next;
  end

endmodule

// File: rtl/compare_sched.sv
// Round-robin scheduler feeding a registered operand-versus-constant comparator.
// Optional result statistics are built when COMPARE_SCHED_STATS_EN is defined.
module compare_sched
  import compare_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MCONSTANT  = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
  output logic [1:0]                          rsp_sign,
  output logic                                busy
`ifdef COMPARE_SCHED_STATS_EN
  ,
  input  logic                                stats_clr,
  output logic [STATS_W-1:0]                  cnt_gt,
  output logic [STATS_W-1:0]                  cnt_eq,
  output logic [STATS_W-1:0]                  cnt_lt
`endif
);

  localparam int unsigned           ID_W    = $clog2(NUM_REQ);
  localparam logic [DATA_WIDTH-1:0] K_TRUNC = DATA_WIDTH'(MCONSTANT);

  state_t                 state;
  logic [ID_W-1:0]        rr_ptr;
  logic [DATA_WIDTH-1:0]  operand_q;
  logic                   grant_found;
  logic [ID_W-1:0]        grant_idx;
  logic [ID_W-1:0]        cand;

  // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = ID_W'((32'(rr_ptr) + 32'(i)) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Grant is only offered in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      operand_q <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_found) begin
            operand_q <= req_data[grant_idx];
            rsp_id    <= grant_idx;
            rr_ptr    <= ID_W'(wrap_inc(32'(grant_idx), NUM_REQ));
            state     <= CMP;
          end
        end
        CMP: begin
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // operand_q only moves on acceptance, so the registered sign holds through RSP.
  compare_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .MCONSTANT  (K_TRUNC)
  ) u_compare_core (
    .clk         (clk),
    .reset       (reset),
    .A           (operand_q),
    .sign_result (rsp_sign)
  );

`ifdef COMPARE_SCHED_STATS_EN
  logic handshake;
  assign handshake = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_gt <= '0;
      cnt_eq <= '0;
      cnt_lt <= '0;
    end else if (stats_clr) begin
      cnt_gt <= '0;
      cnt_eq <= '0;
      cnt_lt <= '0;
    end else if (handshake) begin
      case (rsp_sign)
        SIGN_GT: if (cnt_gt != '1) cnt_gt <= cnt_gt + 1'b1;
        SIGN_EQ: if (cnt_eq != '1) cnt_eq <= cnt_eq + 1'b1;
        SIGN_LT: if (cnt_lt != '1) cnt_lt <= cnt_lt + 1'b1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_compare_sched.sv
// Directed bench for compare_sched: four instances sharing stimulus, each with a
// different MCONSTANT, so one arbitration sequence exercises several comparisons.
module tb_compare_sched;

  localparam int unsigned KS [4] = '{32'd5, 32'd4, 32'h3FFFE, 32'h3FFFF};
  localparam int K5 = 0, K4 = 1, KFE = 2, KFF = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0][17:0] req_data;
  logic             rsp_ready;

  logic [3:0] req_ready [4];
  logic       rsp_valid [4];
  logic [1:0] rsp_id    [4];
  logic [1:0] rsp_sign  [4];
  logic       busy      [4];
`ifdef COMPARE_SCHED_STATS_EN
  logic        stats_clr;
  logic [15:0] cnt_gt [4];
  logic [15:0] cnt_eq [4];
  logic [15:0] cnt_lt [4];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    compare_sched #(
      .DATA_WIDTH (18),
      .NUM_REQ    (4),
      .MCONSTANT  (KS[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id[g]),
      .rsp_sign  (rsp_sign[g]),
      .busy      (busy[g])
`ifdef COMPARE_SCHED_STATS_EN
      ,
      .stats_clr (stats_clr),
      .cnt_gt    (cnt_gt[g]),
      .cnt_eq    (cnt_eq[g]),
      .cnt_lt    (cnt_lt[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] s2_sign [4] = '{2'b00, 2'b10, 2'b00, 2'b10};

  initial begin
    reset     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_data  = '0;
    req_data[0] = 18'd5;
`ifdef COMPARE_SCHED_STATS_EN
    stats_clr = 1'b0;
`endif

    // Reset values, with a request pending that must not be granted.
    repeat (2) step();
    check("rst_ready", 32'(req_ready[K5]), 32'h0);
    check("rst_valid", 32'(rsp_valid[K5]), 32'h0);
    check("rst_id",    32'(rsp_id[K5]),    32'h0);
    check("rst_sign",  32'(rsp_sign[K5]),  32'h0);
    check("rst_busy",  32'(busy[K5]),      32'h0);

    // Scenario 1: grant in the first cycle after release, result two cycles later.
    reset = 1'b0;
    #1;
    check("s1_ready_c0", 32'(req_ready[K5]), 32'h1);
    step();
    req_valid = 4'b0000;
    #1;
    check("s1_valid_c1", 32'(rsp_valid[K5]), 32'h0);
    check("s1_busy_c1",  32'(busy[K5]),      32'h1);
    step();
    check("s1_valid_c2", 32'(rsp_valid[K5]), 32'h1);
    check("s1_id",       32'(rsp_id[K5]),    32'h0);
    check("s1_sign_eq",  32'(rsp_sign[K5]),  32'h1);
    check("s1_sign_gt",  32'(rsp_sign[K4]),  32'h2);
    check("s1_sign_lt",  32'(rsp_sign[KFE]), 32'h0);
    step();
    check("s1_idle_busy",  32'(busy[K5]),      32'h0);
    check("s1_idle_valid", 32'(rsp_valid[K5]), 32'h0);

    // Scenario 2: all valid, grants rotate 0..3, one result every 3 cycles.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_data[0] = 18'd1;
    req_data[1] = 18'd9;
    req_data[2] = 18'd3;
    req_data[3] = 18'd7;
    req_valid   = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("s2_ready", 32'(req_ready[K4]), 32'(1 << k));
      step();
      check("s2_cmp_valid", 32'(rsp_valid[K4]), 32'h0);
      check("s2_cmp_ready", 32'(req_ready[K4]), 32'h0);
      step();
      check("s2_valid", 32'(rsp_valid[K4]), 32'h1);
      check("s2_id",    32'(rsp_id[K4]),    32'(k));
      check("s2_sign",  32'(rsp_sign[K4]),  32'(s2_sign[k]));
      if (k == 3) req_valid = 4'b0000;
      step();
    end
    check("s2_end_busy", 32'(busy[K4]), 32'h0);

    // Scenario 3: consumer stalls for 10 cycles; response holds, no new grants.
    rsp_ready   = 1'b0;
    req_valid   = 4'b0100;
    req_data[2] = 18'd4;
    #1;
    check("s3_ready", 32'(req_ready[K4]), 32'h4);
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      check("s3_hold_valid", 32'(rsp_valid[K4]), 32'h1);
      check("s3_hold_id",    32'(rsp_id[K4]),    32'h2);
      check("s3_hold_sign",  32'(rsp_sign[K4]),  32'h1);
      check("s3_hold_ready", 32'(req_ready[K4]), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    #1;
    check("s3_release_valid", 32'(rsp_valid[K4]), 32'h1);
    step();
    check("s3_after_valid", 32'(rsp_valid[K4]), 32'h0);

    // Scenario 4: reset during CMP drops the operand and restarts the pointer.
    req_valid   = 4'b0010;
    req_data[1] = 18'd9;
    #1;
    check("s4_ready", 32'(req_ready[K4]), 32'h2);
    step();
    check("s4_in_cmp", 32'(busy[K4]), 32'h1);
    reset = 1'b1;
    #1;
    check("s4_rst_valid", 32'(rsp_valid[K4]), 32'h0);
    check("s4_rst_id",    32'(rsp_id[K4]),    32'h0);
    check("s4_rst_sign",  32'(rsp_sign[K4]),  32'h0);
    check("s4_rst_busy",  32'(busy[K4]),      32'h0);
    check("s4_rst_ready", 32'(req_ready[K4]), 32'h0);
    req_valid   = 4'b1111;
    req_data[0] = 18'd4;
    step();
    check("s4_no_rsp", 32'(rsp_valid[K4]), 32'h0);
    reset = 1'b0;
    #1;
    check("s4_first_grant", 32'(req_ready[K4]), 32'h1);
    step();
    req_valid = 4'b0000;
    #1;
    check("s4_cmp_valid", 32'(rsp_valid[K4]), 32'h0);
    step();
    check("s4_rsp_valid", 32'(rsp_valid[K4]), 32'h1);
    check("s4_rsp_id",    32'(rsp_id[K4]),    32'h0);
    check("s4_rsp_sign",  32'(rsp_sign[K4]),  32'h1);
    step();

    // Re-arbitration every IDLE cycle; pointer is now 1.
    req_valid = 4'b1001;
    #1;
    check("rr_wrap", 32'(req_ready[K4]), 32'h8);
    req_valid = 4'b0001;
    #1;
    check("rr_drop", 32'(req_ready[K4]), 32'h1);
    req_valid   = 4'b1000;
    req_data[3] = 18'h3FFFF;
    #1;
    check("rr_regrant", 32'(req_ready[K4]), 32'h8);

    // Scenario 5: full-width compare at the top of the 18-bit range.
    step();
    req_valid = 4'b0000;
    step();
    check("s5_valid",   32'(rsp_valid[KFE]), 32'h1);
    check("s5_id",      32'(rsp_id[KFE]),    32'h3);
    check("s5_gt_fe",   32'(rsp_sign[KFE]),  32'h2);
    check("s5_eq_ff",   32'(rsp_sign[KFF]),  32'h1);
    check("s5_gt_k4",   32'(rsp_sign[K4]),   32'h2);
    step();

`ifdef COMPARE_SCHED_STATS_EN
    // Scenario 6: saturating greater-than counter, then clear beats increment.
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("s6_cleared", 32'(cnt_gt[K4]), 32'h0);
    req_data  = {18'd9, 18'd9, 18'd9, 18'd9};
    req_valid = 4'b1111;
    repeat (3 * 70000) step();
    check("s6_sat_gt", 32'(cnt_gt[K4]), 32'hFFFF);
    check("s6_eq",     32'(cnt_eq[K4]), 32'h0);
    check("s6_lt",     32'(cnt_lt[K4]), 32'h0);
    step();
    step();
    check("s6_in_rsp", 32'(rsp_valid[K4]), 32'h1);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    req_valid = 4'b0000;
    check("s6_clr_prio", 32'(cnt_gt[K4]), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
